preemph_seq_ctrl: RTL and testbench

Sequencer for the pre-emphasis stage at the front of the log-mel pipeline. It accepts a start command with an utterance length, clears the pre-emphasis history register, and passes source samples to the datapath under a valid/ready handshake with downstream backpressure. It counts accepted samples and tags frame boundaries (sof/eof, non-overlapping FRAME_LEN windows) and the utterance end for the framing/FFT stages. It returns to idle when the utterance completes or on abort.

---
 rtl/preemph_seq_ctrl.sv | 108 ++++++++++
 tb/tb_preemph_seq_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/preemph_seq_ctrl.sv
// Pre-emphasis sequencer: clears filter history, gates source samples to the datapath
// under valid/ready, and tags frame and utterance boundaries for the downstream framing stages.
module preemph_seq_ctrl #(
  parameter int FRAME_LEN = 400,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_samples_i,
  input  logic             abort_i,
  input  logic             src_valid_i,
  output logic             src_ready_o,
  input  logic             dst_ready_i,
  output logic             pe_clr_o,
  output logic             pe_valid_o,
  output logic             sof_o,
  output logic             eof_o,
  output logic             last_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int FRM_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [FRM_W-1:0] frm_pos_q, frm_pos_d;
  logic             xfer;
  logic             smp_last;
  logic             frm_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      smp_cnt_q <= '0;
      frm_pos_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      smp_cnt_q <= smp_cnt_d;
      frm_pos_q <= frm_pos_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    smp_cnt_d = smp_cnt_q;
    frm_pos_d = frm_pos_q;

    // Ready is a pure pass-through of downstream ready while running; no skid buffer.
    src_ready_o = (state_q == S_RUN) & dst_ready_i;
    xfer        = src_valid_i & src_ready_o;
    smp_last    = (smp_cnt_q == (len_q - CNT_W'(1)));
    frm_last    = (frm_pos_q == FRM_LAST);

    pe_valid_o = xfer;
    sof_o      = xfer & (frm_pos_q == '0);
    eof_o      = xfer & (frm_last | smp_last);
    last_o     = xfer & smp_last;
    pe_clr_o   = (state_q == S_CLEAR);
    busy_o     = (state_q != S_IDLE);
    done_o     = (state_q == S_DONE);

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d   = num_samples_i;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        smp_cnt_d = '0;
        frm_pos_d = '0;
        state_d   = (len_q == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (xfer) begin
          smp_cnt_d = smp_cnt_q + CNT_W'(1);
          frm_pos_d = frm_last ? '0 : frm_pos_q + FRM_W'(1);
          if (smp_last) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything, including a start pulse arriving in IDLE.
    if (abort_i) begin
      state_d   = S_IDLE;
      len_d     = len_q;
      smp_cnt_d = '0;
      frm_pos_d = '0;
    end
  end

endmodule

// File: tb/tb_preemph_seq_ctrl.sv
// Bench for preemph_seq_ctrl: scenario table plus randomized runs, checked cycle by
// cycle against a model built from sample indices and event cycle numbers.
module tb_preemph_seq_ctrl;
  localparam int FL = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [CW-1:0] num_samples_i = '0;
  logic          abort_i = 1'b0;
  logic          src_valid_i = 1'b0;
  logic          src_ready_o;
  logic          dst_ready_i = 1'b0;
  logic          pe_clr_o, pe_valid_o, sof_o, eof_o, last_o, busy_o, done_o;

  int checks = 0;
  int errors = 0;

  preemph_seq_ctrl #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .num_samples_i(num_samples_i),
    .abort_i(abort_i), .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .dst_ready_i(dst_ready_i), .pe_clr_o(pe_clr_o), .pe_valid_o(pe_valid_o),
    .sof_o(sof_o), .eof_o(eof_o), .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    bit bp;
    int abort_at;
    bit ign;
    int exp_x;
    bit exp_done;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, src_ready_o, 0);
    chk({tag, "_valid"}, pe_valid_o, 0);
    chk({tag, "_clr"}, pe_clr_o, 0);
    chk({tag, "_flags"}, {sof_o, eof_o, last_o}, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
  endtask

  // Cycle 0 carries the start pulse; clear is expected at 1, the run window opens at 2.
  // fin is the cycle of the terminating event (final transfer, clear of an empty run, or abort).
  task automatic run_utt(input int len, input bit bp, input int abort_at, input bit ign,
                         input int exp_x, input bit exp_done);
    int  n_exp = 0, n_act = 0, n_done = 0, n_clr = 0, fin = -1;
    bit  ab = 1'b0;
    bit  win, xf;
    for (int cyc = 0; ; cyc++) begin
      if (cyc > 1000) begin
        chk("timeout", 1, 0);
        break;
      end
      if (fin >= 0 && cyc > fin + 3) break;
      @(negedge clk);
      win           = (cyc >= 2) && (fin < 0) && (len > 0);
      start_i       = (cyc == 0) || (ign && cyc == 4);
      num_samples_i = (cyc == 0) ? CW'(len) : CW'(99);
      src_valid_i   = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      dst_ready_i   = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      abort_i       = 1'b0;
      if (win && abort_at >= 0 && n_exp == abort_at) begin
        abort_i     = 1'b1;
        src_valid_i = 1'b1;
        dst_ready_i = 1'b1;
      end
      xf = win & src_valid_i & dst_ready_i;
      #1;
      chk("src_ready", src_ready_o, win & dst_ready_i);
      chk("pe_valid", pe_valid_o, xf);
      chk("pe_clr", pe_clr_o, cyc == 1);
      chk("busy", busy_o, (cyc >= 1) && (fin < 0 || cyc <= fin + (ab ? 0 : 1)));
      chk("done", done_o, !ab && fin >= 0 && cyc == fin + 1);
      chk("sof", sof_o, xf && (n_exp % FL == 0));
      chk("eof", eof_o, xf && ((n_exp % FL == FL - 1) || (n_exp == len - 1)));
      chk("last", last_o, xf && (n_exp == len - 1));
      n_act  += int'(pe_valid_o);
      n_clr  += int'(pe_clr_o);
      n_done += int'(done_o);
      if (xf) begin
        n_exp++;
        if (n_exp == len) fin = cyc;
      end
      if (len == 0 && cyc == 1) fin = 1;
      if (abort_i) begin
        ab  = 1'b1;
        fin = cyc;
      end
    end
    start_i     = 1'b0;
    abort_i     = 1'b0;
    src_valid_i = 1'b0;
    dst_ready_i = 1'b0;
    chk("n_xfers", n_act, exp_x);
    chk("n_done", n_done, int'(exp_done));
    chk("n_clr", n_clr, 1);
    $display("run len=%0d bp=%0d abort_at=%0d ign=%0d xfers=%0d done=%0d",
             len, bp, abort_at, ign, n_act, n_done);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{10, 1'b0, -1, 1'b0, 10, 1'b1};
    vecs[1] = '{10, 1'b1, -1, 1'b0, 10, 1'b1};
    vecs[2] = '{ 0, 1'b0, -1, 1'b0,  0, 1'b1};
    vecs[3] = '{10, 1'b0,  5, 1'b0,  6, 1'b0};
    vecs[4] = '{ 3, 1'b0, -1, 1'b0,  3, 1'b1};
    vecs[5] = '{10, 1'b0, -1, 1'b1, 10, 1'b1};
    vecs[6] = '{ 1, 1'b1, -1, 1'b0,  1, 1'b1};
    vecs[7] = '{ 4, 1'b0, -1, 1'b0,  4, 1'b1};
    vecs[8] = '{ 9, 1'b1, -1, 1'b1,  9, 1'b1};

    #2;
    chk_idle_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_idle_outputs("post_reset");

    foreach (vecs[i])
      run_utt(vecs[i].len, vecs[i].bp, vecs[i].abort_at, vecs[i].ign,
              vecs[i].exp_x, vecs[i].exp_done);

    for (int r = 0; r < 8; r++) begin
      int len, ab_at;
      len   = $urandom_range(0, 25);
      ab_at = (len > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      run_utt(len, 1'b1, ab_at, 1'b0, (ab_at >= 0) ? ab_at + 1 : len, ab_at < 0);
    end

    // Reset asserted mid-run must silence every output at once.
    @(negedge clk);
    start_i       = 1'b1;
    num_samples_i = CW'(10);
    src_valid_i   = 1'b1;
    dst_ready_i   = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("midrun_valid", pe_valid_o, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("rst_midrun");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk_idle_outputs("rst_release");
    src_valid_i = 1'b0;
    dst_ready_i = 1'b0;
    run_utt(5, 1'b0, -1, 1'b0, 5, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
